// File: rtl/player_1_key_decoder.sv
// player_1_key_decoder: turns PS/2 set-2 make/break byte streams into
// level-sensitive move_* controls for the player-1 sprite drawer.
// Optional build macro PLAYER_1_ARROW_KEYS_EN adds the extended arrow keys;
// without it extended sequences are parsed and discarded.
//
// state       | meaning
// ------------+------------------------------------------------
// S_IDLE      | waiting for a plain make code or a prefix byte
// S_EXT       | saw E0, next non-prefix byte is an extended make
// S_BREAK     | saw F0, next non-prefix byte is a plain break
// S_EXT_BREAK | saw E0 F0, next non-prefix byte is an extended break
module player_1_key_decoder #(
   parameter int unsigned PREFIX_TIMEOUT = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] scancode,
   input  logic       scancode_valid,
   output logic       move_up,
   output logic       move_down,
   output logic       move_right,
   output logic       move_left
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXT,
      S_BREAK,
      S_EXT_BREAK
   } state_t;

   localparam logic [7:0]  CODE_EXT     = 8'hE0;
   localparam logic [7:0]  CODE_BREAK   = 8'hF0;
   localparam logic [7:0]  CODE_BAT_OK  = 8'hAA;
   localparam logic [19:0] TIMEOUT_LAST = 20'(PREFIX_TIMEOUT - 1);

   // held bit order: [0]=up [1]=down [2]=right [3]=left
   function automatic logic [3:0] plain_map(input logic [7:0] code);
      case (code)
         8'h1D:   plain_map = 4'b0001;
         8'h1B:   plain_map = 4'b0010;
         8'h23:   plain_map = 4'b0100;
         8'h1C:   plain_map = 4'b1000;
         default: plain_map = 4'b0000;
      endcase
   endfunction

   state_t      state, state_nxt;
   logic [19:0] wd_cnt, wd_cnt_nxt;
   logic [3:0]  held_wasd, held_wasd_nxt;
   logic [3:0]  held_arrow;
   logic        is_prefix;
   logic        up_any, down_any, right_any, left_any;

   assign is_prefix = (scancode == CODE_EXT) || (scancode == CODE_BREAK);

`ifdef PLAYER_1_ARROW_KEYS_EN
   logic [3:0] held_arrow_nxt;

   function automatic logic [3:0] arrow_map(input logic [7:0] code);
      case (code)
         8'h75:   arrow_map = 4'b0001;
         8'h72:   arrow_map = 4'b0010;
         8'h74:   arrow_map = 4'b0100;
         8'h6B:   arrow_map = 4'b1000;
         default: arrow_map = 4'b0000;
      endcase
   endfunction

   // arrow held bits, only present when the arrow keys are built in
   always_ff @(posedge clk) begin
      if (rst) held_arrow <= '0;
      else     held_arrow <= held_arrow_nxt;
   end
`else
   assign held_arrow = 4'b0000;
`endif

   // state, watchdog and plain held-key registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         wd_cnt    <= '0;
         held_wasd <= '0;
      end else begin
         state     <= state_nxt;
         wd_cnt    <= wd_cnt_nxt;
         held_wasd <= held_wasd_nxt;
      end
   end

   // sequence parsing; a valid byte always takes priority over watchdog expiry
   always_comb begin
      state_nxt     = state;
      wd_cnt_nxt    = '0;
      held_wasd_nxt = held_wasd;
`ifdef PLAYER_1_ARROW_KEYS_EN
      held_arrow_nxt = held_arrow;
`endif
      if (scancode_valid) begin
         case (state)
            S_IDLE: begin
               if (scancode == CODE_EXT)
                  state_nxt = S_EXT;
               else if (scancode == CODE_BREAK)
                  state_nxt = S_BREAK;
               else if (scancode == CODE_BAT_OK) begin
                  held_wasd_nxt = '0;
`ifdef PLAYER_1_ARROW_KEYS_EN
                  held_arrow_nxt = '0;
`endif
               end else
                  held_wasd_nxt = held_wasd | plain_map(scancode);
            end
            S_EXT: begin
               if (scancode == CODE_BREAK)
                  state_nxt = S_EXT_BREAK;
               else if (scancode != CODE_EXT) begin
`ifdef PLAYER_1_ARROW_KEYS_EN
                  held_arrow_nxt = held_arrow | arrow_map(scancode);
`endif
                  state_nxt = S_IDLE;
               end
            end
            S_BREAK: begin
               if (!is_prefix) begin
                  held_wasd_nxt = held_wasd & ~plain_map(scancode);
                  state_nxt     = S_IDLE;
               end
            end
            S_EXT_BREAK: begin
               if (!is_prefix) begin
`ifdef PLAYER_1_ARROW_KEYS_EN
                  held_arrow_nxt = held_arrow & ~arrow_map(scancode);
`endif
                  state_nxt = S_IDLE;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end else if (state != S_IDLE) begin
         if (wd_cnt == TIMEOUT_LAST)
            state_nxt = S_IDLE;
         else
            wd_cnt_nxt = wd_cnt + 20'd1;
      end
   end

   assign up_any    = held_wasd[0] | held_arrow[0];
   assign down_any  = held_wasd[1] | held_arrow[1];
   assign right_any = held_wasd[2] | held_arrow[2];
   assign left_any  = held_wasd[3] | held_arrow[3];

   // registered outputs with opposite-direction cancellation
   always_ff @(posedge clk) begin
      if (rst) begin
         move_up    <= 1'b0;
         move_down  <= 1'b0;
         move_right <= 1'b0;
         move_left  <= 1'b0;
      end else begin
         move_up    <= up_any & ~down_any;
         move_down  <= down_any & ~up_any;
         move_right <= right_any & ~left_any;
         move_left  <= left_any & ~right_any;
      end
   end

endmodule

// File: tb/tb_player_1_key_decoder.sv
// Directed bench for player_1_key_decoder; expectations follow the build macro
// PLAYER_1_ARROW_KEYS_EN when it is defined.
module tb_player_1_key_decoder;

   localparam logic [3:0] NONE = 4'b0000;
   localparam logic [3:0] UP   = 4'b0001;
   localparam logic [3:0] DN   = 4'b0010;
   localparam logic [3:0] RT   = 4'b0100;
   localparam logic [3:0] LT   = 4'b1000;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] scancode;
   logic       scancode_valid;
   logic       move_up, move_down, move_right, move_left;
   logic [3:0] mv;

   int checks = 0;
   int errors = 0;

   player_1_key_decoder #(.PREFIX_TIMEOUT(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .scancode       (scancode),
      .scancode_valid (scancode_valid),
      .move_up        (move_up),
      .move_down      (move_down),
      .move_right     (move_right),
      .move_left      (move_left)
   );

   always #5 clk = ~clk;

   assign mv = {move_left, move_right, move_down, move_up};

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (L R D U)", tag, got, exp);
      end
   endtask

   // one-cycle strobe; consecutive calls produce back-to-back strobes
   task automatic send(input logic [7:0] b);
      scancode       = b;
      scancode_valid = 1'b1;
      @(posedge clk);
      #1;
      scancode_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst            = 1'b1;
      scancode       = 8'h00;
      scancode_valid = 1'b0;
      idle(3);
      rst = 1'b0;
      check("reset", mv, NONE);

      // W make with two-cycle latency, then release
      send(8'h1D);
      check("w_not_yet", mv, NONE);
      idle(1);
      check("w_make", mv, UP);
      send(8'hF0);
      send(8'h1D);
      check("w_break_not_yet", mv, UP);
      idle(1);
      check("w_break", mv, NONE);

      // W and S cancel; releasing S leaves up
      send(8'h1D);
      send(8'h1B);
      idle(1);
      check("ws_cancel", mv, NONE);
      send(8'hF0);
      send(8'h1B);
      idle(1);
      check("s_release", mv, UP);
      send(8'hF0);
      send(8'h1D);
      idle(1);
      check("w_release2", mv, NONE);

      // typematic repeat, back-to-back
      send(8'h23);
      idle(1);
      check("d_make", mv, RT);
      send(8'h23);
      send(8'h23);
      check("d_repeat", mv, RT);
      idle(1);
      check("d_repeat2", mv, RT);
      send(8'hF0);
      send(8'h23);
      idle(1);
      check("d_break", mv, NONE);

      // F0 with a gap shorter than the timeout is still a break
      send(8'h1C);
      idle(1);
      check("a_make", mv, LT);
      send(8'hF0);
      idle(10);
      send(8'h1C);
      idle(1);
      check("a_break_slow", mv, NONE);

      // watchdog expiry abandons the break and keeps held keys
      send(8'h1D);
      send(8'hF0);
      idle(20);
      check("wd_keep_w", mv, UP);
      send(8'h1C);
      idle(1);
      check("wd_make_a", mv, UP | LT);
      send(8'hF0);
      send(8'h1C);
      send(8'hF0);
      send(8'h1D);
      idle(1);
      check("wd_cleanup", mv, NONE);

      // self-test pass clears held keys
      send(8'h1C);
      send(8'h23);
      idle(1);
      check("ad_cancel", mv, NONE);
      send(8'hAA);
      idle(1);
      check("aa_clear", mv, NONE);
      send(8'h23);
      idle(1);
      check("aa_then_d", mv, RT);
      send(8'hF0);
      send(8'h23);
      idle(1);
      check("aa_cleanup", mv, NONE);

      // extended sequences
      send(8'hE0);
      send(8'h1D);
      idle(1);
      check("ext_1d_ignored", mv, NONE);
      send(8'hE0);
      send(8'h75);
      idle(1);
`ifdef PLAYER_1_ARROW_KEYS_EN
      check("arrow_up_make", mv, UP);
`else
      check("arrow_up_make", mv, NONE);
`endif
      send(8'hE0);
      send(8'hF0);
      send(8'h75);
      idle(1);
      check("arrow_up_break", mv, NONE);
      send(8'h1D);
      send(8'hE0);
      send(8'hF0);
      send(8'h1D);
      idle(1);
      check("ext_break_keeps_w", mv, UP);
      send(8'hF0);
      send(8'h1D);
      idle(1);
      check("ext_cleanup", mv, NONE);

      // reset mid-sequence clears keys and restarts parsing in IDLE
      send(8'h23);
      send(8'hF0);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      check("mid_reset", mv, NONE);
      send(8'h1D);
      idle(1);
      check("after_reset", mv, UP);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
